// File: rtl/corr_peak_find.sv
// Sequential arg-max over N_DISP captured correlation scores, one candidate compared per clock.
// Optional second-best tracking and `margin` output when CORR_PEAK_CONF_EN is defined.
module corr_peak_find #(
  parameter int CORR_W = 16,
  parameter int N_DISP = 21,
  parameter int IDX_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wen,
  input  logic [N_DISP*CORR_W-1:0] corr_in,
  output logic                     busy,
  output logic                     out_valid,
  output logic [IDX_W-1:0]         best_idx,
  output logic [CORR_W-1:0]        best_val,
  output logic                     overrun
`ifdef CORR_PEAK_CONF_EN
  ,
  output logic [CORR_W-1:0]        margin
`endif
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DISP - 1);

  state_t state_reg, state_next;

  logic [CORR_W-1:0] corr_arr   [N_DISP];
  logic [CORR_W-1:0] shadow_reg [N_DISP];
  logic [IDX_W-1:0]  ptr_reg;
  logic [CORR_W-1:0] run_best_reg;
  logic [IDX_W-1:0]  run_idx_reg;
  logic              out_valid_reg;
  logic [IDX_W-1:0]  best_idx_reg;
  logic [CORR_W-1:0] best_val_reg;
  logic              overrun_reg;

  logic [CORR_W-1:0] cur_score;
  logic              is_greater;
  logic              is_last;
  logic [CORR_W-1:0] best_next;
  logic [IDX_W-1:0]  idx_next;

  for (genvar gi = 0; gi < N_DISP; gi++) begin : g_unpack
    assign corr_arr[gi] = corr_in[gi*CORR_W +: CORR_W];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (wen) state_next = SCAN;
      SCAN:    if (is_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_reg == SCAN);
  end

  // Strict greater-than keeps the lower index on ties.
  assign cur_score  = shadow_reg[ptr_reg];
  assign is_greater = cur_score > run_best_reg;
  assign is_last    = (ptr_reg == LAST_IDX);
  assign best_next  = is_greater ? cur_score : run_best_reg;
  assign idx_next   = is_greater ? ptr_reg   : run_idx_reg;

`ifdef CORR_PEAK_CONF_EN
  logic [CORR_W-1:0] second_reg;
  logic [CORR_W-1:0] second_next;
  logic [CORR_W-1:0] margin_reg;

  always_comb begin
    second_next = second_reg;
    if (is_greater)
      second_next = run_best_reg;
    else if (cur_score > second_reg)
      second_next = cur_score;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      second_reg <= '0;
      margin_reg <= '0;
    end else if (state_reg == IDLE && wen) begin
      second_reg <= '0;
    end else if (state_reg == SCAN) begin
      second_reg <= second_next;
      if (is_last) margin_reg <= best_next - second_next;
    end
  end

  assign margin = margin_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_DISP; k++) shadow_reg[k] <= '0;
      ptr_reg       <= '0;
      run_best_reg  <= '0;
      run_idx_reg   <= '0;
      out_valid_reg <= 1'b0;
      best_idx_reg  <= '0;
      best_val_reg  <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      if (state_reg == IDLE && wen) begin
        for (int k = 0; k < N_DISP; k++) shadow_reg[k] <= corr_arr[k];
        run_best_reg <= corr_arr[0];
        run_idx_reg  <= '0;
        ptr_reg      <= IDX_W'(1);
      end else if (state_reg == SCAN) begin
        run_best_reg <= best_next;
        run_idx_reg  <= idx_next;
        if (is_last) begin
          best_idx_reg  <= idx_next;
          best_val_reg  <= best_next;
          out_valid_reg <= 1'b1;
          ptr_reg       <= '0;
        end else begin
          ptr_reg <= ptr_reg + IDX_W'(1);
        end
      end
      // A frame arriving mid-scan is dropped; the shadow copy is left intact.
      if (state_reg == SCAN && wen) overrun_reg <= 1'b1;
    end
  end

  assign out_valid = out_valid_reg;
  assign best_idx  = best_idx_reg;
  assign best_val  = best_val_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_corr_peak_find.sv
// Scoreboard bench for corr_peak_find: stimulus pushes expected results, a monitor pops them on out_valid.
// Margin checks are compiled in when CORR_PEAK_CONF_EN is defined.
module tb_corr_peak_find;

  localparam int CORR_W = 16;
  localparam int N_DISP = 21;
  localparam int IDX_W  = 5;
  localparam int LAT    = N_DISP - 1;

  typedef struct {
    int idx;
    int val;
    int mrg;
    int cyc;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     wen = 1'b0;
  logic [N_DISP*CORR_W-1:0] corr_in = '0;
  logic                     busy;
  logic                     out_valid;
  logic [IDX_W-1:0]         best_idx;
  logic [CORR_W-1:0]        best_val;
  logic                     overrun;
  logic [CORR_W-1:0]        margin_w;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  logic [CORR_W-1:0] sc [N_DISP];

  corr_peak_find #(.CORR_W(CORR_W), .N_DISP(N_DISP), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .wen       (wen),
    .corr_in   (corr_in),
    .busy      (busy),
    .out_valid (out_valid),
    .best_idx  (best_idx),
    .best_val  (best_val),
    .overrun   (overrun)
`ifdef CORR_PEAK_CONF_EN
    ,
    .margin    (margin_w)
`endif
  );

`ifndef CORR_PEAK_CONF_EN
  assign margin_w = '0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every out_valid must match the oldest expected result.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("result idx=%0d val=0x%0h margin=%0d cyc=%0d", best_idx, best_val, margin_w, cyc);
        chk("best_idx", int'(best_idx), e.idx);
        chk("best_val", int'(best_val), e.val);
        chk("latency",  cyc, e.cyc);
`ifdef CORR_PEAK_CONF_EN
        chk("margin",   int'(margin_w), e.mrg);
`endif
      end
    end
  end

  function automatic logic [N_DISP*CORR_W-1:0] pack_scores();
    logic [N_DISP*CORR_W-1:0] b;
    for (int k = 0; k < N_DISP; k++) b[k*CORR_W +: CORR_W] = sc[k];
    return b;
  endfunction

  // Called at a negedge: presents the frame for one cycle.
  task automatic send(input bit expect_res, input int e_idx, input int e_val, input int e_mrg);
    exp_t e;
    corr_in = pack_scores();
    wen = 1'b1;
    if (expect_res) begin
      e.idx = e_idx; e.val = e_val; e.mrg = e_mrg; e.cyc = cyc + 1 + LAT;
      sb.push_back(e);
    end
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic fill(input int base);
    for (int k = 0; k < N_DISP; k++) sc[k] = CORR_W'(base);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy",      busy,      0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_best_idx",  best_idx,  0);
    chk("rst_best_val",  best_val,  0);
    chk("rst_overrun",   overrun,   0);
    chk("rst_margin",    margin_w,  0);
    rst = 1'b0;
    @(negedge clk);

    // Ramp: busy rises on capture and falls with out_valid.
    for (int k = 0; k < N_DISP; k++) sc[k] = CORR_W'(10 * k);
    send(1'b1, 20, 200, 10);
    chk("ramp_busy_rise", busy, 1);
    repeat (LAT - 1) @(negedge clk);
    chk("ramp_busy_held", busy, 1);
    chk("ramp_no_early_valid", out_valid, 0);
    @(negedge clk);
    chk("ramp_busy_fall", busy, 0);
    chk("ramp_valid", out_valid, 1);
    @(negedge clk);
    chk("valid_one_cycle", out_valid, 0);

    // Tie keeps the lower index.
    fill(100); sc[3] = 16'd500; sc[17] = 16'd500;
    send(1'b1, 3, 500, 0);
    wait_result(); @(negedge clk);

    // All zero still produces one result.
    fill(0);
    send(1'b1, 0, 0, 0);
    wait_result(); @(negedge clk);

    // Overrun: second wen sampled on the 5th scan edge is dropped.
    fill(5); sc[9] = 16'h1234;
    send(1'b1, 9, 16'h1234, 16'h122F);
    repeat (4) @(negedge clk);
    fill(0); sc[2] = 16'hFFFF;
    send(1'b0, 0, 0, 0);
    chk("overrun_set", overrun, 1);
    chk("overrun_busy", busy, 1);
    wait_result();
    repeat (30) @(negedge clk);
    chk("overrun_sticky", overrun, 1);

    // Reset on the 10th scan edge aborts the frame.
    for (int k = 0; k < N_DISP; k++) sc[k] = CORR_W'(10 * k);
    send(1'b0, 0, 0, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy",     busy,     0);
    chk("midrst_best_idx", best_idx, 0);
    chk("midrst_best_val", best_val, 0);
    chk("midrst_overrun",  overrun,  0);
    repeat (25) @(negedge clk);
    chk("midrst_idle", busy, 0);

    fill(100); sc[3] = 16'd500; sc[17] = 16'd500;
    send(1'b1, 3, 500, 0);
    wait_result(); @(negedge clk);

    // Back-to-back: new frame accepted in the out_valid cycle.
    for (int k = 0; k < N_DISP; k++) sc[k] = CORR_W'(10 * k);
    send(1'b1, 20, 200, 10);
    wait_result();
    fill(1); sc[7] = 16'hFFFF;
    send(1'b1, 7, 16'hFFFF, 16'hFFFE);
    chk("b2b_busy", busy, 1);
    wait_result();
    repeat (5) @(negedge clk);
    chk("b2b_no_overrun", overrun, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
